// File: rtl/agen_stage.sv
// LC-3b address-generation stage: selects and extends the opcode's offset field, adds it to the
// PC or base register, and passes the result downstream through a registered output and a skid slot.
module agen_stage #(
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_ir,
  input  logic [15:0] in_pc,
  input  logic [15:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [3:0]  out_kind,
  output logic        out_misaligned,
  output logic [15:0] out_ir
);

  localparam logic [3:0] KNone = 4'd0;
  localparam logic [3:0] KLdb  = 4'd1;
  localparam logic [3:0] KStb  = 4'd2;
  localparam logic [3:0] KLdw  = 4'd3;
  localparam logic [3:0] KStw  = 4'd4;
  localparam logic [3:0] KLdi  = 4'd5;
  localparam logic [3:0] KSti  = 4'd6;
  localparam logic [3:0] KLea  = 4'd7;
  localparam logic [3:0] KBr   = 4'd8;
  localparam logic [3:0] KJsr  = 4'd9;
  localparam logic [3:0] KJmp  = 4'd10;
  localparam logic [3:0] KTrap = 4'd11;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  kind;
    logic        mis;
    logic [15:0] ir;
  } entry_t;

  logic [15:0] off9, off11, off6, off6s, trapv;
  logic [15:0] calc_addr;
  logic [3:0]  calc_kind;
  logic        align_chk;
  entry_t      calc;

  assign off9  = {{6{in_ir[8]}}, in_ir[8:0], 1'b0};
  assign off11 = {{4{in_ir[10]}}, in_ir[10:0], 1'b0};
  assign off6  = {{10{in_ir[5]}}, in_ir[5:0]};
  assign off6s = {{9{in_ir[5]}}, in_ir[5:0], 1'b0};
  assign trapv = {7'd0, in_ir[7:0], 1'b0};

  always_comb begin
    calc_addr = 16'h0000;
    calc_kind = KNone;
    align_chk = 1'b0;
    unique case (in_ir[15:12])
      4'b0000: begin calc_addr = in_pc + off9;  calc_kind = KBr;  end
      4'b1110: begin calc_addr = in_pc + off9;  calc_kind = KLea; end
      4'b0100: begin
        calc_kind = KJsr;
        if (in_ir[11]) begin
          calc_addr = in_pc + off11;
        end else begin
          calc_addr = in_base;
          align_chk = 1'b1;
        end
      end
      4'b1100: begin calc_addr = in_base;         calc_kind = KJmp; align_chk = 1'b1; end
      4'b0010: begin calc_addr = in_base + off6;  calc_kind = KLdb; end
      4'b0011: begin calc_addr = in_base + off6;  calc_kind = KStb; end
      4'b0110: begin calc_addr = in_base + off6s; calc_kind = KLdw; align_chk = 1'b1; end
      4'b0111: begin calc_addr = in_base + off6s; calc_kind = KStw; align_chk = 1'b1; end
      4'b1010: begin calc_addr = in_base + off6s; calc_kind = KLdi; align_chk = 1'b1; end
      4'b1011: begin calc_addr = in_base + off6s; calc_kind = KSti; align_chk = 1'b1; end
      4'b1111: begin calc_addr = trapv;           calc_kind = KTrap; end
      default: begin calc_addr = 16'h0000;        calc_kind = KNone; end
    endcase
  end

  assign calc.addr = calc_addr;
  assign calc.kind = calc_kind;
  assign calc.mis  = (CHECK_ALIGN != 0) && align_chk && calc_addr[0];
  assign calc.ir   = in_ir;

  entry_t out_q, skid_q;
  logic   out_valid_q, skid_valid_q;
  logic   accept, fire;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (in_flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (fire) begin
      // A full skid implies in_ready was low, so no accept can collide with the drain.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q <= calc;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept) begin
        out_q       <= calc;
        out_valid_q <= 1'b1;
      end
    end else if (accept) begin
      skid_q       <= calc;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_addr       = out_q.addr;
  assign out_kind       = out_q.kind;
  assign out_misaligned = out_q.mis;
  assign out_ir         = out_q.ir;

endmodule

// File: tb/tb_agen_stage.sv
// Directed bench for agen_stage: address/kind/alignment vectors, backpressure, flush and reset.
module tb_agen_stage;

  logic        clk = 1'b0;
  logic        reset, in_flush, in_valid, out_ready;
  logic [15:0] in_ir, in_pc, in_base;
  logic        in_ready, out_valid, out_misaligned;
  logic [15:0] out_addr, out_ir;
  logic [3:0]  out_kind;
  logic        in_ready2, out_valid2, out_misaligned2;
  logic [15:0] out_addr2, out_ir2;
  logic [3:0]  out_kind2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agen_stage #(.CHECK_ALIGN(1)) dut (
    .clk(clk), .reset(reset), .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_base(in_base), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_kind(out_kind),
    .out_misaligned(out_misaligned), .out_ir(out_ir)
  );

  agen_stage #(.CHECK_ALIGN(0)) dut_noalign (
    .clk(clk), .reset(reset), .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ir(in_ir), .in_pc(in_pc), .in_base(in_base), .out_valid(out_valid2),
    .out_ready(out_ready), .out_addr(out_addr2), .out_kind(out_kind2),
    .out_misaligned(out_misaligned2), .out_ir(out_ir2)
  );

  // ir, pc, base -> addr, kind, misaligned (CHECK_ALIGN=1)
  logic [15:0] v_ir   [12] = '{16'h6283, 16'h05FF, 16'hF025, 16'hC080, 16'h2281, 16'h4802,
                               16'h4080, 16'h7FBF, 16'h1234, 16'hE005, 16'hA081, 16'h3FBF};
  logic [15:0] v_pc   [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000,
                               16'h0000, 16'h0000, 16'h5555, 16'h3000, 16'h0000, 16'h0000};
  logic [15:0] v_base [12] = '{16'h3000, 16'h0000, 16'h0000, 16'h4001, 16'h4000, 16'h0000,
                               16'h2003, 16'h1000, 16'h5555, 16'h0000, 16'h2001, 16'h1000};
  logic [15:0] v_addr [12] = '{16'h3006, 16'hFFFE, 16'h004A, 16'h4001, 16'h4001, 16'h1004,
                               16'h2003, 16'h0FFE, 16'h0000, 16'h300A, 16'h2003, 16'h0FFF};
  logic [3:0]  v_kind [12] = '{4'd3, 4'd8, 4'd11, 4'd10, 4'd1, 4'd9,
                               4'd9, 4'd4, 4'd0, 4'd7, 4'd5, 4'd2};
  logic        v_mis  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                       input logic [15:0] base);
    in_valid = v;
    in_ir    = ir;
    in_pc    = pc;
    in_base  = base;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_handshake: got %b expected 01", {out_valid, in_ready});
    end
    n_checks++;
    if ({out_addr, out_kind, out_ir, out_misaligned} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got addr=%h kind=%h ir=%h mis=%b expected all zero",
               out_addr, out_kind, out_ir, out_misaligned);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 16'h6283, 16'h0000, 16'h3000);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if ({out_valid, out_addr, out_kind, out_misaligned} !== {1'b1, 16'h3006, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL single_ldw: got v=%b addr=%h kind=%0d mis=%b expected v=1 addr=3006 kind=3 mis=0",
               out_valid, out_addr, out_kind, out_misaligned);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v_ir[i], v_pc[i], v_base[i]);
      tick();
      n_checks++;
      if ({out_valid, out_addr, out_kind, out_misaligned, out_ir} !==
          {1'b1, v_addr[i], v_kind[i], v_mis[i], v_ir[i]}) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%b addr=%h kind=%0d mis=%b ir=%h expected v=1 addr=%h kind=%0d mis=%b ir=%h",
                 i, out_valid, out_addr, out_kind, out_misaligned, out_ir,
                 v_addr[i], v_kind[i], v_mis[i], v_ir[i]);
      end
      n_checks++;
      if ({out_valid2, out_misaligned2, out_addr2} !== {1'b1, 1'b0, v_addr[i]}) begin
        n_fail++;
        $display("FAIL noalign_vec%0d: got v=%b mis=%b addr=%h expected v=1 mis=0 addr=%h",
                 i, out_valid2, out_misaligned2, out_addr2, v_addr[i]);
      end
    end
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h6283, 16'h0000, 16'h3000);  // A -> 3006
    tick();
    drive(1'b1, 16'h2281, 16'h0000, 16'h3000);  // B -> 3001
    tick();
    drive(1'b1, 16'hF025, 16'h0000, 16'h3000);  // C -> 004A
    n_checks++;
    if ({out_valid, out_ir, in_ready} !== {1'b1, 16'h6283, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_skid_full: got v=%b ir=%h in_ready=%b expected v=1 ir=6283 in_ready=0",
               out_valid, out_ir, in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_ir, out_addr, in_ready} !== {1'b1, 16'h6283, 16'h3006, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b ir=%h addr=%h in_ready=%b expected v=1 ir=6283 addr=3006 in_ready=0",
               out_valid, out_ir, out_addr, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_ir, out_addr, in_ready} !== {1'b1, 16'h2281, 16'h3001, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b ir=%h addr=%h in_ready=%b expected v=1 ir=2281 addr=3001 in_ready=1",
               out_valid, out_ir, out_addr, in_ready);
    end
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if ({out_valid, out_ir, out_addr, out_kind} !== {1'b1, 16'hF025, 16'h004A, 4'd11}) begin
      n_fail++;
      $display("FAIL bp_third: got v=%b ir=%h addr=%h kind=%0d expected v=1 ir=F025 addr=004A kind=11",
               out_valid, out_ir, out_addr, out_kind);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 16'h6283, 16'h0000, 16'h3000);
    tick();
    drive(1'b1, 16'h2281, 16'h0000, 16'h3000);
    tick();
    drive(1'b1, 16'hE005, 16'h3000, 16'h0000);
    in_flush  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_clear: got v=%b in_ready=%b expected v=0 in_ready=1",
                         out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got out_valid=%b expected 0", out_valid);
    end
    // Flush while the stage is empty and accepting: the offered input must be dropped.
    drive(1'b1, 16'hE005, 16'h3000, 16'h0000);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_accept_drop: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 16'h6283, 16'h0000, 16'h3000);
    tick();
    drive(1'b1, 16'h2281, 16'h0000, 16'h3000);
    tick();
    reset    = 1'b1;
    in_flush = 1'b1;
    tick();
    reset    = 1'b0;
    in_flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if ({out_valid, in_ready, out_addr, out_kind, out_ir} !== {1'b0, 1'b1, 36'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b in_ready=%b addr=%h kind=%0d ir=%h expected 0,1,0000,0,0000",
               out_valid, in_ready, out_addr, out_kind, out_ir);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_ghost: got out_valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
